unit_output_collector: RTL
==========================

# unit_output_collector

Downstream stage for the `sha256unit` instances. It drains result packets from N_UNITS unit output queues (`dout`/`rd_en`/`empty` style) and merges them into a single output word stream for the output FIFO. Arbitration is round-robin over units with data pending, and each packet is transferred whole, with no interleaving between units.

## Interface
Parameters:
- N_UNITS, 4: number of attached units (1..16).
- DIN_WIDTH, 16: unit output word width, which equals the unit's UNIT_OUTPUT_WIDTH.
- PKT_WORDS, 18: words per result packet (2..256).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- unit_dout  in  N_UNITS*DIN_WIDTH  unit i word at [DIN_WIDTH*i +: DIN_WIDTH]; first-word-fall-through, valid while unit_empty[i]=0.
- unit_empty  in  N_UNITS  unit i has no word available.
- unit_rd_en  out  N_UNITS  consume the current word of unit i. Combinational; at most one bit is high.
- dout  out  DIN_WIDTH  registered output word.
- wr_en  out  1  registered write strobe for dout.
- afull  in  1  output FIFO almost full. The FIFO guarantees room for at least 2 more words after afull rises.
- idle  out  1  high in state IDLE.
- cur_unit  out  4  index of the granted unit (valid outside IDLE).

## Operation
- The block runs a state machine with states IDLE, XFER and CSUM. CSUM is only present when the checksum feature is compiled in.
- **IDLE:**
  - Scan unit_empty starting from index (last_served+1) mod N_UNITS. last_served resets to N_UNITS-1, so the first scan starts at unit 0.
  - Grant the first unit with empty=0: latch cur_unit, clear word counter cnt and checksum, and go to XFER.
  - With no candidate, stay in IDLE.
- **XFER:**
  - unit_rd_en[cur_unit] = ~unit_empty[cur_unit] & ~afull.
  - On each read:
    - register the word into dout;
    - assert wr_en for one cycle;
    - XOR the word into the checksum;
    - cnt++.
  - When the read with cnt==PKT_WORDS-1 occurs, set last_served=cur_unit. Then go to CSUM if the feature is enabled, otherwise to IDLE.
  - If the granted unit goes empty mid-packet, stall: no read and no wr_en, and the grant is held indefinitely. Other units are never read during the stall.
- **CSUM:**
  - When afull=0, put the checksum on dout with wr_en=1 and go to IDLE.
  - Otherwise wait.
- cnt is 8 bits wide and compared to PKT_WORDS-1. It never wraps within a packet.
- wr_en is asserted only in the cycle after a read, or in the cycle after a CSUM emit. There are no other writes.
- **Simultaneous events:**
  - afull and empty both deasserting in the same cycle: the read happens that cycle.
  - Several units becoming non-empty together: the round-robin order decides which is granted.
- **Reset:**
  - RST=1 forces state IDLE, cnt=0, checksum=0, last_served=N_UNITS-1, wr_en=0, dout=0, cur_unit=0.
  - Because unit_rd_en is combinational, RST=1 also forces it to all-zero in that same cycle.
  - A packet in flight is abandoned. Its remaining words stay in the unit queue and are treated as the start of the next packet. Upstream must be reset together with this block.

## Timing
- Reset values: unit_rd_en=0, dout=0, wr_en=0, idle=1, cur_unit=0.
- Grant latency: unit becomes non-empty in cycle t, IDLE grants at edge t, and the first read is in cycle t+1.
- Read-to-write latency: a word read in cycle t appears with wr_en=1 in cycle t+1.
- Throughput:
  - 1 word/cycle while the unit is non-empty and afull=0.
  - Without the checksum feature, a packet takes PKT_WORDS cycles plus 1 IDLE cycle between packets.
  - With the checksum feature, each packet needs 1 additional cycle for CSUM.
- afull is sampled in the same cycle as the read decision. Because dout is registered, one write can still occur after afull rises; the 2-word margin on the output FIFO covers this.

## Configuration
- Macro UNIT_OUTPUT_CHECKSUM_EN.
- **Defined:** the CSUM state exists. Each packet on dout is PKT_WORDS data words followed by one word holding the XOR of all its data words (PKT_WORDS+1 words total).
- **Undefined:** there is no CSUM state and no checksum register. Each packet is exactly PKT_WORDS words, and XFER returns directly to IDLE.

## Test plan
- **Single unit, single packet:** N_UNITS=4, unit 2 presents 18 words 0x0001..0x0012, afull=0.
  - 18 consecutive wr_en beats with matching data, cur_unit=2, first write 2 cycles after empty falls.
  - With UNIT_OUTPUT_CHECKSUM_EN defined, a 19th word 0x0013 (XOR of 1..18) follows.
- **Round-robin:** all 4 units hold one packet each from reset.
  - Packets are emitted in unit order 0,1,2,3, with no interleaved words.
  - After refilling, unit 0 is served again only after unit 3.
- **Mid-packet starvation:** unit 1 goes empty after word 5 for 10 cycles while unit 3 is full.
  - Output pauses 10 cycles, then words 6..18 come from unit 1.
  - unit_rd_en[3] stays 0 throughout.
- **Backpressure:** afull toggles every 3 cycles during a packet.
  - No read occurs while afull=1.
  - All 18 words arrive in order with no duplicates or losses.
  - At most 1 write occurs after each afull rise.
- **Reset mid-packet:** RST is pulsed for 1 cycle after word 7 of unit 0.
  - In the pulse cycle: unit_rd_en=0 and wr_en=0.
  - The next cycle: idle=1.
  - The next grant again starts at unit 0.

Source files
------------

// File: rtl/unit_output_collector.sv
// -----------------------------------------------------------------------------
// unit_output_collector
//
// Drains whole result packets from N_UNITS first-word-fall-through unit output
// queues and merges them into one registered word stream for the output FIFO.
// Units with data pending are served round-robin. A granted packet is moved
// in full before any other unit is looked at.
//
// Build option:
//   UNIT_OUTPUT_CHECKSUM_EN - when defined, every packet is followed by one
//                             extra word holding the XOR of its data words.
//
// Ports:
//   CLK         clock
//   RST         synchronous active-high reset
//   unit_dout   unit i word at [DIN_WIDTH*i +: DIN_WIDTH], valid while empty=0
//   unit_empty  unit i has no word available
//   unit_rd_en  combinational pop strobe, at most one bit high
//   dout        registered output word
//   wr_en       registered write strobe for dout
//   afull       output FIFO almost full (at least 2 words of room remain)
//   idle        high while no unit is granted
//   cur_unit    index of the granted unit
//
// States:
//   ST_IDLE | scanning for the next unit with data, round-robin
//   ST_XFER | moving words of one packet from cur_unit
//   ST_CSUM | emitting the packet checksum word (checksum build only)
// -----------------------------------------------------------------------------
module unit_output_collector #(
  parameter int N_UNITS   = 4,
  parameter int DIN_WIDTH = 16,
  parameter int PKT_WORDS = 18
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_UNITS*DIN_WIDTH-1:0] unit_dout,
  input  logic [N_UNITS-1:0]           unit_empty,
  output logic [N_UNITS-1:0]           unit_rd_en,
  output logic [DIN_WIDTH-1:0]         dout,
  output logic                         wr_en,
  input  logic                         afull,
  output logic                         idle,
  output logic [3:0]                   cur_unit
);

`ifdef UNIT_OUTPUT_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_XFER} state_t;
`endif

  localparam logic [7:0] LAST_CNT      = 8'(PKT_WORDS - 1);
  localparam logic [3:0] LAST_UNIT_RST = 4'(N_UNITS - 1);
  localparam logic [4:0] N_UNITS_5     = 5'(N_UNITS);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [3:0]               r_last_served;
  logic [3:0]               r_cur_unit;
  logic [7:0]               r_cnt;
  logic [DIN_WIDTH-1:0]     r_dout;
  logic                     r_wr_en;
`ifdef UNIT_OUTPUT_CHECKSUM_EN
  logic [DIN_WIDTH-1:0]     r_csum;
`endif

  // Inputs padded to 16 units so a 4-bit unit index always selects in range;
  // absent units read as permanently empty.
  logic [15:0]              w_empty_pad;
  logic [16*DIN_WIDTH-1:0]  w_dout_pad;
  logic [DIN_WIDTH-1:0]     w_cur_word;
  logic [15:0]              w_rd_pad;
  logic                     w_rd;
  logic                     w_last_rd;
  logic [4:0]               w_scan_idx;
  logic                     w_grant_found;
  logic [3:0]               w_grant_idx;

  always_comb begin
    w_empty_pad                = '1;
    w_empty_pad[N_UNITS-1:0]   = unit_empty;
    w_dout_pad                 = '0;
    w_dout_pad[N_UNITS*DIN_WIDTH-1:0] = unit_dout;
  end

  assign w_cur_word = w_dout_pad[DIN_WIDTH*r_cur_unit +: DIN_WIDTH];

  // Round-robin scan starting after the last served unit. Walking the offsets
  // from farthest to nearest leaves the nearest requester as the grant.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_scan_idx    = '0;
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      w_scan_idx = 5'(r_last_served) + 5'd1 + 5'(i);
      if (w_scan_idx >= N_UNITS_5) begin
        w_scan_idx = w_scan_idx - N_UNITS_5;
      end
      if (!w_empty_pad[w_scan_idx[3:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_scan_idx[3:0];
      end
    end
  end

  // RST gates the read so nothing is popped in the reset cycle itself.
  assign w_rd      = (r_state == ST_XFER) && !w_empty_pad[r_cur_unit] && !afull && !RST;
  assign w_last_rd = w_rd && (r_cnt == LAST_CNT);

  always_comb begin
    w_rd_pad             = '0;
    w_rd_pad[r_cur_unit] = w_rd;
  end

  assign unit_rd_en = w_rd_pad[N_UNITS-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_found) begin
          w_state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (w_last_rd) begin
`ifdef UNIT_OUTPUT_CHECKSUM_EN
          w_state_nxt = ST_CSUM;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef UNIT_OUTPUT_CHECKSUM_EN
      ST_CSUM: begin
        if (!afull) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_served <= LAST_UNIT_RST;
      r_cur_unit    <= '0;
      r_cnt         <= '0;
      r_dout        <= '0;
      r_wr_en       <= 1'b0;
`ifdef UNIT_OUTPUT_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if ((r_state == ST_IDLE) && w_grant_found) begin
        r_cur_unit <= w_grant_idx;
        r_cnt      <= '0;
`ifdef UNIT_OUTPUT_CHECKSUM_EN
        r_csum     <= '0;
`endif
      end
      if (w_rd) begin
        r_dout  <= w_cur_word;
        r_wr_en <= 1'b1;
        r_cnt   <= r_cnt + 8'd1;
`ifdef UNIT_OUTPUT_CHECKSUM_EN
        r_csum  <= r_csum ^ w_cur_word;
`endif
        if (w_last_rd) begin
          r_last_served <= r_cur_unit;
        end
      end
`ifdef UNIT_OUTPUT_CHECKSUM_EN
      if ((r_state == ST_CSUM) && !afull) begin
        r_dout  <= r_csum;
        r_wr_en <= 1'b1;
      end
`endif
    end
  end

  assign dout     = r_dout;
  assign wr_en    = r_wr_en;
  assign idle     = (r_state == ST_IDLE);
  assign cur_unit = r_cur_unit;

endmodule
